// File: rtl/ins_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage: opcode and
// compressed-quadrant encodings, BHT reset value, FSM state and decode kinds.
package ins_fetch_pkg;

  localparam int DAT_W = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Low two bits of a 32-bit instruction; anything else is compressed.
  localparam logic [1:0] Q_RV32I = 2'b11;
  localparam logic [1:0] C_Q1    = 2'b01;
  localparam logic [1:0] C_Q2    = 2'b10;

  localparam logic [2:0] C_F3_JAL  = 3'b001;
  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;
  localparam logic [2:0] C_F3_JR   = 3'b100;

  localparam logic [1:0] BHT_RST = 2'b01;  // weakly not taken

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  typedef enum logic [2:0] {
    K_SEQ,
    K_JAL,
    K_JALR,
    K_BR,
    K_CJ,
    K_CBR
  } kind_t;

  typedef struct packed {
    logic             ic;
    logic [DAT_W-1:0] ins;
    logic [DAT_W-1:0] pc;
    logic             pbr;
  } dec_t;

endpackage

// File: rtl/ins_fetch_if.sv
// Fetch-stage buses: instruction cache request/response, decoder issue,
// downstream stall and ROB redirect/training.
interface ins_fetch_if;
  import ins_fetch_pkg::*;

  logic             stall_i;
  logic             ic_req_o;
  logic [DAT_W-1:0] ic_addr_o;
  logic             ic_ready_i;
  logic [DAT_W-1:0] ic_ins_i;
  logic             dec_en_o;
  logic             dec_ic_o;
  logic [DAT_W-1:0] dec_ins_o;
  logic [DAT_W-1:0] dec_pc_o;
  logic             dec_pbr_o;
  logic             rob_flush_i;
  logic [DAT_W-1:0] rob_pc_i;
  logic             rob_br_en_i;
  logic [DAT_W-1:0] rob_br_pc_i;
  logic             rob_br_tk_i;

  modport master (
    input  stall_i,
    output ic_req_o, ic_addr_o,
    input  ic_ready_i, ic_ins_i,
    output dec_en_o, dec_ic_o, dec_ins_o, dec_pc_o, dec_pbr_o,
    input  rob_flush_i, rob_pc_i, rob_br_en_i, rob_br_pc_i, rob_br_tk_i
  );

  modport slave (
    output stall_i,
    input  ic_req_o, ic_addr_o,
    output ic_ready_i, ic_ins_i,
    input  dec_en_o, dec_ic_o, dec_ins_o, dec_pc_o, dec_pbr_o,
    output rob_flush_i, rob_pc_i, rob_br_en_i, rob_br_pc_i, rob_br_tk_i
  );

endinterface

// File: rtl/ins_fetch_bht.sv
// Branch history table: 2-bit saturating counters, one combinational read
// port (returns the taken bit) and one registered update port.
module ins_fetch_bht
  import ins_fetch_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BHT_BITS-1:0] rd_idx,
  output logic                rd_tk,
  input  logic                upd_en,
  input  logic [BHT_BITS-1:0] upd_idx,
  input  logic                upd_tk
);

  localparam int ENTRIES = 1 << BHT_BITS;

  logic [1:0] ctr_q [ENTRIES];

  // Reading the array directly means a same-cycle update is not yet visible.
  assign rd_tk = ctr_q[rd_idx][1];

  always_ff @(posedge clk) begin
    // NOTE: every counter must start weakly-not-taken, so this array is reset
    // entry by entry; that keeps it in flops rather than a RAM macro.
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_RST;
      end
    end else if (upd_en) begin
      if (upd_tk && ctr_q[upd_idx] != 2'b11) begin
        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
      end else if (!upd_tk && ctr_q[upd_idx] != 2'b00) begin
        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: owns the PC, requests the I-cache, classifies RV32I/RV32C,
// predicts the next PC and issues one instruction at a time to the decoder.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter logic [DAT_W-1:0] RESET_PC = '0,
  parameter int               BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  ins_fetch_if.master bus
);

  state_t           state_q, state_d;
  logic [DAT_W-1:0] pc_q, pc_d;
  logic             drop_q, drop_d;
  logic             dec_en_q, dec_en_d;
  dec_t             dec_q, dec_d;

  logic [DAT_W-1:0] ins;
  logic [DAT_W-1:0] imm_j, imm_b, imm_cj, imm_cb;
  logic [DAT_W-1:0] seq_pc, nxt_pc;
  logic             is_c, pbr, bht_tk, ic_req;
  kind_t            kind;
  logic             unused_br_pc;

  assign ins    = bus.ic_ins_i;
  assign is_c   = ins[1:0] != Q_RV32I;
  assign seq_pc = pc_q + (is_c ? DAT_W'(2) : DAT_W'(4));

  assign imm_j  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_b  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_cj = {{20{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                   ins[2], ins[11], ins[5:3], 1'b0};
  assign imm_cb = {{23{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10],
                   ins[4:3], 1'b0};

  // Only the index bits of the resolved-branch PC address the table.
  assign unused_br_pc = ^{bus.rob_br_pc_i[DAT_W-1:BHT_BITS+1], bus.rob_br_pc_i[0]};

  ins_fetch_bht #(.BHT_BITS(BHT_BITS)) u_bht (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (pc_q[BHT_BITS:1]),
    .rd_tk  (bht_tk),
    .upd_en (bus.rob_br_en_i),
    .upd_idx(bus.rob_br_pc_i[BHT_BITS:1]),
    .upd_tk (bus.rob_br_tk_i)
  );

  always_comb begin
    kind = K_SEQ;
    if (!is_c) begin
      case (ins[6:0])
        OPC_JAL:    kind = K_JAL;
        OPC_BRANCH: kind = K_BR;
        OPC_JALR:   kind = K_JALR;
        default:    ;
      endcase
    end else if (ins[1:0] == C_Q1) begin
      case (ins[15:13])
        C_F3_J, C_F3_JAL:     kind = K_CJ;
        C_F3_BEQZ, C_F3_BNEZ: kind = K_CBR;
        default:              ;
      endcase
    end else if (ins[1:0] == C_Q2 && ins[15:13] == C_F3_JR &&
                 ins[6:2] == 5'd0 && ins[11:7] != 5'd0) begin
      kind = K_JALR;
    end
  end

  // Register-indirect jumps cannot be predicted here and fall through.
  always_comb begin
    nxt_pc = seq_pc;
    pbr    = 1'b0;
    case (kind)
      K_JAL: nxt_pc = pc_q + imm_j;
      K_CJ:  nxt_pc = pc_q + imm_cj;
      K_BR: begin
        pbr = bht_tk;
        if (bht_tk) nxt_pc = pc_q + imm_b;
      end
      K_CBR: begin
        pbr = bht_tk;
        if (bht_tk) nxt_pc = pc_q + imm_cb;
      end
      default: ;
    endcase
  end

  assign ic_req = (state_q == S_IDLE) && en && !rst && !bus.stall_i && !bus.rob_flush_i;

  always_comb begin
    // NOTE: every variable gets its hold/idle value first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    dec_en_d = 1'b0;
    dec_d    = dec_q;

    if (bus.rob_flush_i) begin
      pc_d = bus.rob_pc_i;
      if (bus.ic_ready_i) begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end else if (state_q == S_WAIT) begin
        drop_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ic_ready_i && drop_q) drop_d = 1'b0;
          if (ic_req) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.ic_ready_i) begin
            state_d = S_IDLE;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              pc_d     = nxt_pc;
              dec_en_d = 1'b1;
              dec_d    = '{ic: is_c, ins: (is_c ? {16'h0, ins[15:0]} : ins),
                           pc: pc_q, pbr: pbr};
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A reset that lands on an outstanding request must swallow its response.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      drop_q   <= (state_q == S_WAIT || drop_q) && !bus.ic_ready_i;
      dec_en_q <= 1'b0;
      dec_q    <= '0;
    end else if (en) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      dec_en_q <= dec_en_d;
      dec_q    <= dec_d;
    end
  end

  assign bus.ic_req_o  = ic_req;
  assign bus.ic_addr_o = pc_q;
  assign bus.dec_en_o  = dec_en_q;
  assign bus.dec_ic_o  = dec_q.ic;
  assign bus.dec_ins_o = dec_q.ins;
  assign bus.dec_pc_o  = dec_q.pc;
  assign bus.dec_pbr_o = dec_q.pbr;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: sequential fetch, jumps, BHT-predicted branches,
// flush/drop handling, stall/enable gating and reset during an open request.
module tb_ins_fetch;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   n_checks = 0;
  int   n_fail   = 0;

  ins_fetch_if bus ();

  ins_fetch #(.RESET_PC(32'h0), .BHT_BITS(6)) dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Entered just after a negedge of a cycle with ic_req_o high; returns #1
  // after the negedge of the cycle where the captured instruction is issued.
  task automatic give(input logic [31:0] word, input int lat);
    repeat (1 + lat) @(negedge clk);
    bus.ic_ins_i   = word;
    bus.ic_ready_i = 1'b1;
    @(negedge clk);
    bus.ic_ready_i = 1'b0;
    #1;
  endtask

  // Flush from IDLE: one cycle of rob_flush_i, returns with the new request up.
  task automatic redirect(input logic [31:0] target);
    bus.stall_i     = 1'b0;
    bus.rob_flush_i = 1'b1;
    bus.rob_pc_i    = target;
    @(negedge clk);
    bus.rob_flush_i = 1'b0;
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input int n);
    bus.rob_br_en_i = 1'b1;
    bus.rob_br_pc_i = pc;
    bus.rob_br_tk_i = tk;
    repeat (n) @(negedge clk);
    bus.rob_br_en_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.ic_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.ic_req_o); end
    n_checks++; if (bus.ic_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.ic_addr_o); end
    n_checks++; if (bus.dec_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_dec_en: got %b want 0", bus.dec_en_o); end
    n_checks++; if (bus.dec_pc_o !== 32'h0 || bus.dec_ins_o !== 32'h0) begin n_fail++; $display("FAIL rst_dec: pc %h ins %h want 0", bus.dec_pc_o, bus.dec_ins_o); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (bus.ic_req_o !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.ic_req_o); end
    n_checks++; if (bus.ic_addr_o !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 0", bus.ic_addr_o); end
  endtask

  task automatic test_sequential();
    give(32'h00000513, 0);
    n_checks++; if (bus.dec_en_o !== 1'b1) begin n_fail++; $display("FAIL addi_en: got %b want 1", bus.dec_en_o); end
    n_checks++; if (bus.dec_ic_o !== 1'b0) begin n_fail++; $display("FAIL addi_ic: got %b want 0", bus.dec_ic_o); end
    n_checks++; if (bus.dec_ins_o !== 32'h00000513) begin n_fail++; $display("FAIL addi_ins: got %h want 00000513", bus.dec_ins_o); end
    n_checks++; if (bus.dec_pc_o !== 32'h0) begin n_fail++; $display("FAIL addi_pc: got %h want 0", bus.dec_pc_o); end
    n_checks++; if (bus.ic_addr_o !== 32'h4 || bus.ic_req_o !== 1'b1) begin n_fail++; $display("FAIL addi_next: addr %h req %b want 4/1", bus.ic_addr_o, bus.ic_req_o); end
    give(32'hFFFF0505, 1);
    n_checks++; if (bus.dec_en_o !== 1'b1 || bus.dec_ic_o !== 1'b1) begin n_fail++; $display("FAIL caddi_en_ic: en %b ic %b want 1/1", bus.dec_en_o, bus.dec_ic_o); end
    n_checks++; if (bus.dec_ins_o !== 32'h00000505) begin n_fail++; $display("FAIL caddi_ins: got %h want 00000505", bus.dec_ins_o); end
    n_checks++; if (bus.dec_pc_o !== 32'h4) begin n_fail++; $display("FAIL caddi_pc: got %h want 4", bus.dec_pc_o); end
    n_checks++; if (bus.ic_addr_o !== 32'h6) begin n_fail++; $display("FAIL caddi_next: got %h want 6", bus.ic_addr_o); end
    bus.stall_i = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (bus.dec_en_o !== 1'b0) begin n_fail++; $display("FAIL pulse: dec_en got %b want 0", bus.dec_en_o); end
    n_checks++; if (bus.dec_ins_o !== 32'h00000505 || bus.dec_pc_o !== 32'h4) begin n_fail++; $display("FAIL dec_hold: ins %h pc %h want 505/4", bus.dec_ins_o, bus.dec_pc_o); end
  endtask

  task automatic test_jumps();
    redirect(32'h8);
    n_checks++; if (bus.ic_req_o !== 1'b1 || bus.ic_addr_o !== 32'h8) begin n_fail++; $display("FAIL redirect8: req %b addr %h want 1/8", bus.ic_req_o, bus.ic_addr_o); end
    give(32'h010000EF, 0);
    n_checks++; if (bus.dec_pc_o !== 32'h8 || bus.dec_pbr_o !== 1'b0 || bus.dec_ic_o !== 1'b0) begin n_fail++; $display("FAIL jal_dec: pc %h pbr %b ic %b want 8/0/0", bus.dec_pc_o, bus.dec_pbr_o, bus.dec_ic_o); end
    n_checks++; if (bus.ic_addr_o !== 32'h18) begin n_fail++; $display("FAIL jal_next: got %h want 18", bus.ic_addr_o); end
    give(32'h1234BFF5, 0);
    n_checks++; if (bus.dec_ic_o !== 1'b1 || bus.dec_ins_o !== 32'h0000BFF5 || bus.dec_pc_o !== 32'h18) begin n_fail++; $display("FAIL cj_dec: ic %b ins %h pc %h want 1/BFF5/18", bus.dec_ic_o, bus.dec_ins_o, bus.dec_pc_o); end
    n_checks++; if (bus.ic_addr_o !== 32'h14 || bus.dec_pbr_o !== 1'b0) begin n_fail++; $display("FAIL cj_next: addr %h pbr %b want 14/0", bus.ic_addr_o, bus.dec_pbr_o); end
  endtask

  task automatic test_branch();
    redirect(32'h20);
    give(32'h00000463, 0);
    n_checks++; if (bus.dec_pbr_o !== 1'b0 || bus.ic_addr_o !== 32'h24) begin n_fail++; $display("FAIL beq_fresh: pbr %b addr %h want 0/24", bus.dec_pbr_o, bus.ic_addr_o); end
    bus.stall_i = 1'b1;
    train(32'h20, 1'b1, 2);
    redirect(32'h20);
    give(32'h00000463, 0);
    n_checks++; if (bus.dec_pbr_o !== 1'b1 || bus.ic_addr_o !== 32'h28 || bus.dec_pc_o !== 32'h20) begin n_fail++; $display("FAIL beq_trained: pbr %b addr %h pc %h want 1/28/20", bus.dec_pbr_o, bus.ic_addr_o, bus.dec_pc_o); end
    bus.stall_i = 1'b1;
    train(32'h20, 1'b1, 3);
    train(32'h20, 1'b0, 1);
    redirect(32'h20);
    give(32'h00000463, 0);
    n_checks++; if (bus.dec_pbr_o !== 1'b1 || bus.ic_addr_o !== 32'h28) begin n_fail++; $display("FAIL beq_saturate: pbr %b addr %h want 1/28", bus.dec_pbr_o, bus.ic_addr_o); end
    bus.stall_i = 1'b1;
    train(32'h20, 1'b0, 1);
    redirect(32'h20);
    give(32'h00000463, 0);
    n_checks++; if (bus.dec_pbr_o !== 1'b0 || bus.ic_addr_o !== 32'h24) begin n_fail++; $display("FAIL beq_untrain: pbr %b addr %h want 0/24", bus.dec_pbr_o, bus.ic_addr_o); end
    bus.stall_i = 1'b1;
    train(32'h40, 1'b1, 1);
    redirect(32'h40);
    give(32'h0000C401, 0);
    n_checks++; if (bus.dec_pbr_o !== 1'b1 || bus.dec_ic_o !== 1'b1 || bus.ic_addr_o !== 32'h48) begin n_fail++; $display("FAIL cbeqz_taken: pbr %b ic %b addr %h want 1/1/48", bus.dec_pbr_o, bus.dec_ic_o, bus.ic_addr_o); end
    redirect(32'h42);
    give(32'h0000C401, 0);
    n_checks++; if (bus.dec_pbr_o !== 1'b0 || bus.ic_addr_o !== 32'h44) begin n_fail++; $display("FAIL cbeqz_fresh: pbr %b addr %h want 0/44", bus.dec_pbr_o, bus.ic_addr_o); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.rob_flush_i = 1'b1;
    bus.rob_pc_i    = 32'h100;
    @(negedge clk);
    bus.rob_flush_i = 1'b0;
    #1;
    n_checks++; if (bus.dec_en_o !== 1'b0 || bus.ic_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_wait: dec_en %b req %b want 0/0", bus.dec_en_o, bus.ic_req_o); end
    @(negedge clk);
    bus.ic_ins_i   = 32'h00000513;
    bus.ic_ready_i = 1'b1;
    @(negedge clk);
    bus.ic_ready_i = 1'b0;
    #1;
    n_checks++; if (bus.dec_en_o !== 1'b0) begin n_fail++; $display("FAIL flush_drop: dec_en got %b want 0", bus.dec_en_o); end
    n_checks++; if (bus.ic_req_o !== 1'b1 || bus.ic_addr_o !== 32'h100) begin n_fail++; $display("FAIL flush_target: req %b addr %h want 1/100", bus.ic_req_o, bus.ic_addr_o); end
    give(32'h00000513, 0);
    n_checks++; if (bus.dec_en_o !== 1'b1 || bus.dec_pc_o !== 32'h100 || bus.ic_addr_o !== 32'h104) begin n_fail++; $display("FAIL after_flush: en %b pc %h addr %h want 1/100/104", bus.dec_en_o, bus.dec_pc_o, bus.ic_addr_o); end
    @(negedge clk);
    bus.rob_flush_i = 1'b1;
    bus.rob_pc_i    = 32'h200;
    bus.ic_ins_i    = 32'h00000513;
    bus.ic_ready_i  = 1'b1;
    @(negedge clk);
    bus.rob_flush_i = 1'b0;
    bus.ic_ready_i  = 1'b0;
    #1;
    n_checks++; if (bus.dec_en_o !== 1'b0 || bus.ic_req_o !== 1'b1 || bus.ic_addr_o !== 32'h200) begin n_fail++; $display("FAIL flush_coincide: en %b req %b addr %h want 0/1/200", bus.dec_en_o, bus.ic_req_o, bus.ic_addr_o); end
    give(32'h00000505, 0);
    n_checks++; if (bus.dec_en_o !== 1'b1 || bus.dec_pc_o !== 32'h200 || bus.ic_addr_o !== 32'h202) begin n_fail++; $display("FAIL no_stale_drop: en %b pc %h addr %h want 1/200/202", bus.dec_en_o, bus.dec_pc_o, bus.ic_addr_o); end
  endtask

  task automatic test_stall();
    int req_seen = 0;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ic_req_o !== 1'b0) req_seen++;
    end
    n_checks++; if (req_seen != 0) begin n_fail++; $display("FAIL stall_req: req high %0d of 5 cycles want 0", req_seen); end
    bus.stall_i = 1'b0;
    #1;
    n_checks++; if (bus.ic_req_o !== 1'b1 || bus.ic_addr_o !== 32'h202) begin n_fail++; $display("FAIL stall_resume: req %b addr %h want 1/202", bus.ic_req_o, bus.ic_addr_o); end
    @(negedge clk);
    bus.stall_i    = 1'b1;
    bus.ic_ins_i   = 32'h00000513;
    bus.ic_ready_i = 1'b1;
    @(negedge clk);
    bus.ic_ready_i = 1'b0;
    #1;
    n_checks++; if (bus.dec_en_o !== 1'b1 || bus.dec_pc_o !== 32'h202) begin n_fail++; $display("FAIL stall_in_wait: en %b pc %h want 1/202", bus.dec_en_o, bus.dec_pc_o); end
    n_checks++; if (bus.ic_req_o !== 1'b0 || bus.ic_addr_o !== 32'h206) begin n_fail++; $display("FAIL stall_after: req %b addr %h want 0/206", bus.ic_req_o, bus.ic_addr_o); end
    bus.stall_i = 1'b0;
    en = 1'b0;
    #1;
    n_checks++; if (bus.ic_req_o !== 1'b0) begin n_fail++; $display("FAIL en_gate: req got %b want 0", bus.ic_req_o); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.ic_addr_o !== 32'h206) begin n_fail++; $display("FAIL en_hold: addr got %h want 206", bus.ic_addr_o); end
    en = 1'b1;
    #1;
    n_checks++; if (bus.ic_req_o !== 1'b1) begin n_fail++; $display("FAIL en_resume: req got %b want 1", bus.ic_req_o); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.ic_req_o !== 1'b1 || bus.ic_addr_o !== 32'h0) begin n_fail++; $display("FAIL midrst_req: req %b addr %h want 1/0", bus.ic_req_o, bus.ic_addr_o); end
    n_checks++; if (bus.dec_pc_o !== 32'h0 || bus.dec_en_o !== 1'b0) begin n_fail++; $display("FAIL midrst_dec: pc %h en %b want 0/0", bus.dec_pc_o, bus.dec_en_o); end
    @(negedge clk);
    bus.ic_ins_i   = 32'h00000505;
    bus.ic_ready_i = 1'b1;
    @(negedge clk);
    bus.ic_ready_i = 1'b0;
    #1;
    n_checks++; if (bus.dec_en_o !== 1'b0 || bus.ic_addr_o !== 32'h0) begin n_fail++; $display("FAIL midrst_drop: en %b addr %h want 0/0", bus.dec_en_o, bus.ic_addr_o); end
    give(32'h00000513, 0);
    n_checks++; if (bus.dec_en_o !== 1'b1 || bus.dec_pc_o !== 32'h0 || bus.ic_addr_o !== 32'h4) begin n_fail++; $display("FAIL midrst_refetch: en %b pc %h addr %h want 1/0/4", bus.dec_en_o, bus.dec_pc_o, bus.ic_addr_o); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    en              = 1'b1;
    bus.stall_i     = 1'b0;
    bus.ic_ready_i  = 1'b0;
    bus.ic_ins_i    = 32'h0;
    bus.rob_flush_i = 1'b0;
    bus.rob_pc_i    = 32'h0;
    bus.rob_br_en_i = 1'b0;
    bus.rob_br_pc_i = 32'h0;
    bus.rob_br_tk_i = 1'b0;

    test_reset();
    test_sequential();
    test_jumps();
    test_branch();
    test_flush();
    test_stall();
    test_reset_mid_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
